// File: rtl/ahb_lite_slave_mem_pkg.sv
// Shared encodings for the AHB-Lite memory responder: bus codes, FSM states,
// and the access legality / byte-lane helpers used at address-phase accept.
package ahb_lite_slave_mem_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [2:0] {
      AHB_S_IDLE   = 3'd0,
      AHB_S_WAIT   = 3'd1,
      AHB_S_ACCESS = 3'd2,
      AHB_S_ERR1   = 3'd3,
      AHB_S_ERR2   = 3'd4
   } state_e;

   function automatic logic access_legal(input logic [31:0] haddr,
                                         input logic [2:0]  hsize,
                                         input int unsigned depth);
      logic in_range;
      logic aligned;
      in_range = ({2'b00, haddr[31:2]} < depth);
      case (hsize)
         HSIZE_BYTE: aligned = 1'b1;
         HSIZE_HALF: aligned = ~haddr[0];
         HSIZE_WORD: aligned = (haddr[1:0] == 2'b00);
         default:    aligned = 1'b0;
      endcase
      return in_range & aligned;
   endfunction

   // Little-endian lane enables; only meaningful for accesses already judged legal.
   function automatic logic [3:0] lane_mask(input logic [2:0] hsize,
                                            input logic [1:0] offset);
      logic [3:0] mask;
      case (hsize)
         HSIZE_BYTE: mask = 4'b0001 << offset;
         HSIZE_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: mask = 4'b1111;
         default:    mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/ahb_lite_slave_mem_if.sv
// AHB-Lite slave-side bus bundle; HREADY is the mux-level ready seen by everyone.
interface ahb_lite_slave_mem_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic        HMASTLOCK;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   modport slave (
      input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
      output HRDATA, HREADYOUT, HRESP
   );

   modport master (
      output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
      input  HREADY, HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_lite_slave_mem_sram_array.sv
// Word-organised storage with per-byte write enables and an asynchronous read port,
// so a read in the cycle after a write already sees the committed word.
module ahb_lite_sram_array #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic [3:0]        be,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem_q [DEPTH];

   // Byte-lane write; lanes with be low keep their contents.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite memory responder: address-phase accept and legality check, response FSM
// with programmable wait states, two-cycle ERROR, and byte-lane write decode.
module ahb_lite_slave_mem
   import ahb_lite_slave_mem_pkg::*;
#(
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic                  HCLK,
   input logic                  HRESET,
   ahb_lite_slave_mem_if.slave  bus
);

   localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0]  WS = 4'(WAIT_STATES);

   state_e        state_q, state_d;
   logic [3:0]    wcnt_q, wcnt_d;
   logic [AW+1:0] addr_q, addr_d;
   logic          write_q, write_d;
   logic [2:0]    size_q, size_d;
   logic          hreadyout_q, hreadyout_d;
   logic          hresp_q, hresp_d;

   logic          accept_s;
   logic          legal_s;
   logic [3:0]    be_s;
   logic [31:0]   rdata_s;
   logic          unused_s;

   assign accept_s = bus.HSEL & bus.HREADY &
                     ((bus.HTRANS == HTRANS_NONSEQ) | (bus.HTRANS == HTRANS_SEQ));
   assign legal_s  = access_legal(bus.HADDR, bus.HSIZE, MEM_DEPTH);
   assign unused_s = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK};

   // Next-state: new address phases are only taken where our HREADYOUT is high.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      case (state_q)
         AHB_S_WAIT: begin
            if (wcnt_q == 4'd0) begin
               state_d = AHB_S_ACCESS;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         AHB_S_ERR1: state_d = AHB_S_ERR2;
         AHB_S_IDLE, AHB_S_ACCESS, AHB_S_ERR2: begin
            if (accept_s) begin
               addr_d  = bus.HADDR[AW+1:0];
               write_d = bus.HWRITE;
               size_d  = bus.HSIZE;
               if (!legal_s) begin
                  state_d = AHB_S_ERR1;
               end else if (WS == 4'd0) begin
                  state_d = AHB_S_ACCESS;
               end else begin
                  state_d = AHB_S_WAIT;
                  wcnt_d  = WS - 4'd1;
               end
            end else begin
               state_d = AHB_S_IDLE;
            end
         end
         default: state_d = AHB_S_IDLE;
      endcase
   end

   // Response flags are decoded from the state being entered so they come straight off flops.
   always_comb begin
      hreadyout_d = 1'b1;
      hresp_d     = HRESP_OKAY;
      case (state_d)
         AHB_S_WAIT: hreadyout_d = 1'b0;
         AHB_S_ERR1: begin
            hreadyout_d = 1'b0;
            hresp_d     = HRESP_ERROR;
         end
         AHB_S_ERR2: hresp_d = HRESP_ERROR;
         default: begin
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_OKAY;
         end
      endcase
   end

   // State and transfer registers; async reset abandons any open data phase.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q     <= AHB_S_IDLE;
         wcnt_q      <= 4'd0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         size_q      <= 3'd0;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         size_q      <= size_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   end

   // HWDATA lands at the edge that closes ACCESS; ACCESS is only reached by legal transfers.
   assign be_s = ((state_q == AHB_S_ACCESS) && write_q) ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;

   ahb_lite_sram_array #(
      .DEPTH  (MEM_DEPTH),
      .ADDR_W (AW)
   ) u_sram (
      .clk   (HCLK),
      .addr  (addr_q[AW+1:2]),
      .be    (be_s),
      .wdata (bus.HWDATA),
      .rdata (rdata_s)
   );

   assign bus.HRDATA    = ((state_q == AHB_S_ACCESS) && !write_q) ? rdata_s : 32'h0000_0000;
   assign bus.HREADYOUT = hreadyout_q;
   assign bus.HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Bench: two responders (0 and 2 wait states) driven by a pipelined master task and
// compared cycle by cycle against a byte-array model of the memory and response rules.
module tb_ahb_lite_slave_mem;

   logic HCLK = 1'b0;
   logic rst0, rst2;
   always #5 HCLK = ~HCLK;

   ahb_lite_slave_mem_if bus0();
   ahb_lite_slave_mem_if bus2();

   ahb_lite_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (.HCLK(HCLK), .HRESET(rst0), .bus(bus0.slave));
   ahb_lite_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (.HCLK(HCLK), .HRESET(rst2), .bus(bus2.slave));

   bit          sel;
   logic        m_hsel, m_hwrite, hr_low;
   logic [31:0] m_haddr, m_hwdata;
   logic [2:0]  m_hsize;
   logic [1:0]  m_htrans;

   assign bus0.HSEL = m_hsel & ~sel;      assign bus2.HSEL = m_hsel & sel;
   assign bus0.HADDR = m_haddr;           assign bus2.HADDR = m_haddr;
   assign bus0.HWRITE = m_hwrite;         assign bus2.HWRITE = m_hwrite;
   assign bus0.HSIZE = m_hsize;           assign bus2.HSIZE = m_hsize;
   assign bus0.HTRANS = m_htrans;         assign bus2.HTRANS = m_htrans;
   assign bus0.HWDATA = m_hwdata;         assign bus2.HWDATA = m_hwdata;
   assign bus0.HBURST = 3'b000;           assign bus2.HBURST = 3'b001;
   assign bus0.HPROT = 4'b0011;           assign bus2.HPROT = 4'b0011;
   assign bus0.HMASTLOCK = 1'b0;          assign bus2.HMASTLOCK = 1'b0;
   assign bus0.HREADY = bus0.HREADYOUT & ~hr_low;
   assign bus2.HREADY = bus2.HREADYOUT;

   logic        s_ready, s_resp;
   logic [31:0] s_rdata;
   assign s_ready = sel ? bus2.HREADYOUT : bus0.HREADYOUT;
   assign s_resp  = sel ? bus2.HRESP     : bus0.HRESP;
   assign s_rdata = sel ? bus2.HRDATA    : bus0.HRDATA;

   // kind: 0 = real transfer, 1 = HTRANS IDLE with HSEL, 2 = HSEL low with NONSEQ
   typedef struct {
      int          kind;
      bit          write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          chk;
      bit          exp_err;
      logic [31:0] exp_rdata;
   } xfer_t;

   xfer_t q[$];
   xfer_t tbl [18];
   logic [7:0] mdl [2][1024];
   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit model_legal(input logic [31:0] a, input logic [2:0] sz);
      if (sz > 3'd2) return 1'b0;
      if (a / 4 >= 256) return 1'b0;
      return (a % (32'd1 << sz)) == 0;
   endfunction

   function automatic logic [31:0] model_word(input int s, input logic [31:0] a);
      int base;
      base = int'(a / 4) * 4;
      return {mdl[s][base+3], mdl[s][base+2], mdl[s][base+1], mdl[s][base]};
   endfunction

   task automatic model_write(input int s, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
      int base, nb;
      base = int'(a / 4) * 4;
      nb = 1 << sz;
      for (int b = 0; b < 4; b++) begin
         if (base + b >= int'(a) && base + b < int'(a) + nb) mdl[s][base+b] = d[8*b +: 8];
      end
   endtask

   function automatic xfer_t mk(input int kind, input bit w, input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] d, input bit c, input bit e, input logic [31:0] r);
      xfer_t x;
      x.kind = kind; x.write = w; x.size = sz; x.addr = a; x.wdata = d;
      x.chk = c; x.exp_err = e; x.exp_rdata = r;
      return x;
   endfunction

   // Pipelined master: next address phase overlaps the current data phase.
   task automatic run_q();
      xfer_t dp;
      bit dp_v, rdy, legal;
      int k, i, ws, last, s;
      dp_v = 1'b0; k = 0; i = 0;
      ws = sel ? 2 : 0;
      s  = sel ? 1 : 0;
      while (i < q.size() || dp_v) begin
         if (i < q.size()) begin
            m_hsel   = (q[i].kind != 2);
            m_htrans = (q[i].kind == 1) ? 2'b00 : 2'b10;
            m_haddr  = q[i].addr;
            m_hwrite = q[i].write;
            m_hsize  = q[i].size;
         end else begin
            m_hsel = 1'b0; m_htrans = 2'b00;
         end
         if (dp_v) m_hwdata = dp.wdata;
         @(negedge HCLK);
         rdy = s_ready;
         if (dp_v) begin
            legal = (dp.kind == 0) && model_legal(dp.addr, dp.size);
            last  = (dp.kind != 0) ? 0 : (!legal ? 1 : ws);
            check("ready", 32'(rdy), 32'(k == last));
            check("resp", 32'(s_resp), 32'(dp.kind == 0 && !legal));
            check("rdata", s_rdata, (legal && !dp.write && k == last) ? model_word(s, dp.addr) : 32'h0);
            if (rdy) begin
               check("len", 32'(k), 32'(last));
               if (legal && dp.write) model_write(s, dp.addr, dp.size, dp.wdata);
               if (dp.chk) begin
                  check("tbl_resp", 32'(s_resp), 32'(dp.exp_err));
                  if (dp.kind == 0 && !dp.write && !dp.exp_err) check("tbl_rdata", s_rdata, dp.exp_rdata);
               end
               dp_v = 1'b0;
            end else begin
               k++;
               if (k > last + 3) begin
                  check("timeout", 32'(k), 32'(last));
                  dp_v = 1'b0;
               end
            end
         end
         @(posedge HCLK); #1;
         if (rdy && i < q.size()) begin
            dp = q[i]; dp_v = 1'b1; k = 0; i++;
         end
      end
      q.delete();
      m_hsel = 1'b0; m_htrans = 2'b00;
   endtask

   task automatic prefill();
      for (int w = 0; w < 32; w++) q.push_back(mk(0, 1, 3'd2, 32'(w * 4), $urandom, 1, 0, 0));
      q.push_back(mk(0, 1, 3'd2, 32'h3FC, $urandom, 1, 0, 0));
      run_q();
   endtask

   task automatic random_run(input int n);
      int r;
      logic [31:0] a;
      logic [2:0] sz;
      for (int t = 0; t < n; t++) begin
         r = $urandom_range(0, 15);
         if (r == 0)      a = 32'h400 + 32'($urandom_range(0, 63));
         else if (r == 1) a = 32'h3FC + 32'($urandom_range(0, 3));
         else             a = 32'($urandom_range(0, 127));
         sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         r = $urandom_range(0, 11);
         q.push_back(mk((r == 0) ? 1 : ((r == 1) ? 2 : 0), 1'($urandom_range(0, 1)), sz, a, $urandom, 0, 0, 0));
      end
      run_q();
   endtask

   initial begin
      rst0 = 1'b1; rst2 = 1'b1; sel = 1'b0; hr_low = 1'b0;
      m_hsel = 1'b0; m_htrans = 2'b00; m_haddr = 32'h0; m_hwrite = 1'b0; m_hsize = 3'd2; m_hwdata = 32'h0;
      repeat (2) @(negedge HCLK);
      check("rst_ready0", 32'(bus0.HREADYOUT), 32'd1);
      check("rst_resp0", 32'(bus0.HRESP), 32'd0);
      check("rst_rdata0", bus0.HRDATA, 32'h0);
      check("rst_ready2", 32'(bus2.HREADYOUT), 32'd1);
      check("rst_resp2", 32'(bus2.HRESP), 32'd0);
      rst0 = 1'b0; rst2 = 1'b0;
      @(posedge HCLK); #1;

      sel = 1'b0; prefill();
      sel = 1'b1; prefill();

      tbl[0]  = mk(0, 1, 3'd2, 32'h10,  32'hDEADBEEF, 1, 0, 32'h0);
      tbl[1]  = mk(0, 0, 3'd2, 32'h10,  32'h0,        1, 0, 32'hDEADBEEF);
      tbl[2]  = mk(0, 1, 3'd0, 32'h11,  32'h0000AA00, 1, 0, 32'h0);
      tbl[3]  = mk(0, 1, 3'd1, 32'h12,  32'h12340000, 1, 0, 32'h0);
      tbl[4]  = mk(0, 0, 3'd2, 32'h10,  32'h0,        1, 0, 32'h1234AAEF);
      tbl[5]  = mk(0, 1, 3'd2, 32'h20,  32'hCAFEF00D, 1, 0, 32'h0);
      tbl[6]  = mk(0, 0, 3'd2, 32'h20,  32'h0,        1, 0, 32'hCAFEF00D);
      tbl[7]  = mk(0, 0, 3'd2, 32'h400, 32'h0,        1, 1, 32'h0);
      tbl[8]  = mk(0, 1, 3'd2, 32'h13,  32'hFFFFFFFF, 1, 1, 32'h0);
      tbl[9]  = mk(0, 0, 3'd2, 32'h10,  32'h0,        1, 0, 32'h1234AAEF);
      tbl[10] = mk(1, 1, 3'd2, 32'h10,  32'hFFFFFFFF, 1, 0, 32'h0);
      tbl[11] = mk(2, 1, 3'd2, 32'h10,  32'hFFFFFFFF, 1, 0, 32'h0);
      tbl[12] = mk(0, 0, 3'd2, 32'h10,  32'h0,        1, 0, 32'h1234AAEF);
      tbl[13] = mk(0, 1, 3'd2, 32'h3FC, 32'h0BADCAFE, 1, 0, 32'h0);
      tbl[14] = mk(0, 0, 3'd1, 32'h3FE, 32'h0,        1, 0, 32'h0BADCAFE);
      tbl[15] = mk(0, 0, 3'd3, 32'h10,  32'h0,        1, 1, 32'h0);
      tbl[16] = mk(0, 0, 3'd1, 32'h11,  32'h0,        1, 1, 32'h0);
      tbl[17] = mk(0, 0, 3'd2, 32'h3FD, 32'h0,        1, 1, 32'h0);
      sel = 1'b0;
      for (int n = 0; n < 18; n++) q.push_back(tbl[n]);
      run_q();

      // HREADY low from elsewhere while idle: the address phase must be ignored
      hr_low = 1'b1; m_hsel = 1'b1; m_htrans = 2'b10; m_haddr = 32'h10; m_hwrite = 1'b1; m_hsize = 3'd2;
      @(posedge HCLK); #1;
      hr_low = 1'b0; m_hsel = 1'b0; m_htrans = 2'b00; m_hwdata = 32'hFFFFFFFF;
      @(negedge HCLK);
      check("hrlow_ready", 32'(s_ready), 32'd1);
      check("hrlow_resp", 32'(s_resp), 32'd0);
      @(posedge HCLK); #1;
      q.push_back(mk(0, 0, 3'd2, 32'h10, 32'h0, 1, 0, 32'h1234AAEF));
      run_q();

      // Two-wait-state responder: back-to-back reads, then reset during a write's WAIT
      sel = 1'b1;
      q.push_back(mk(0, 0, 3'd2, 32'h10, 32'h0, 0, 0, 32'h0));
      q.push_back(mk(0, 0, 3'd2, 32'h14, 32'h0, 0, 0, 32'h0));
      q.push_back(mk(0, 0, 3'd2, 32'h400, 32'h0, 1, 1, 32'h0));
      run_q();
      m_hsel = 1'b1; m_htrans = 2'b10; m_haddr = 32'h10; m_hwrite = 1'b1; m_hsize = 3'd2;
      @(negedge HCLK);
      check("rstw_idle", 32'(s_ready), 32'd1);
      @(posedge HCLK); #1;
      m_hsel = 1'b0; m_htrans = 2'b00; m_hwdata = 32'h55555555;
      @(negedge HCLK);
      check("rstw_wait", 32'(s_ready), 32'd0);
      #2 rst2 = 1'b1;
      #1;
      check("rstw_ready", 32'(s_ready), 32'd1);
      check("rstw_resp", 32'(s_resp), 32'd0);
      #1 rst2 = 1'b0;
      @(posedge HCLK); #1;
      q.push_back(mk(0, 0, 3'd2, 32'h10, 32'h0, 1, 0, model_word(1, 32'h10)));
      run_q();

      sel = 1'b0; random_run(200);
      sel = 1'b1; random_run(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
